// File: rtl/mini_alu_core_gen2.sv
// Two-stage fetch/execute ALU sequencer with a private register file, a hardware
// return stack for CALL/RET and stallable valid/ready output channels.
module mini_alu_core_gen2 #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 8,
  parameter int PERIPH_CH   = 2,
  localparam int INSN_W     = 4 + 3 * ADDR_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  output logic [IP_W-1:0]      oIP,
  input  logic [INSN_W-1:0]    iInstruction,
  output logic [7:0]           oLed,
  output logic [DATA_W-1:0]    oOut_Data,
  output logic [PERIPH_CH-1:0] oOut_Valid,
  input  logic [PERIPH_CH-1:0] iOut_Ready,
  output logic                 oStall,
  output logic                 oStackOvf,
  output logic                 oStackUnf
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int CH_W = (PERIPH_CH > 1) ? $clog2(PERIPH_CH) : 1;
  localparam logic [ADDR_W:0] CH_LIMIT = (ADDR_W + 1)'(PERIPH_CH);
  localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_STO = 4'd3,
    OP_BLE = 4'd4, OP_JMP = 4'd5, OP_CALL = 4'd6, OP_RET = 4'd7,
    OP_LED = 4'd8, OP_MUL = 4'd9, OP_BNRDY = 4'd10, OP_PUTI = 4'd11,
    OP_PUTR = 4'd12
  } opcode_e;

  typedef enum logic {CH_IDLE, CH_WAIT} ch_state_e;

  logic [INSN_W-1:0] ir;
  logic [IP_W-1:0]   ip;
  logic [SP_W-1:0]   sp;
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [IP_W-1:0]   stack [STACK_DEPTH];
  logic [DATA_W-1:0] data_hold;
  ch_state_e         ch_state, ch_next;

  opcode_e           op;
  logic [ADDR_W-1:0] dst, src1, src0;
  logic [DATA_W-1:0] opa, opb, imm;
  logic [IP_W-1:0]   jump_target, target;
  logic [SP_W-2:0]   top_idx;
  logic [CH_W-1:0]   dst_ch, src0_ch;
  logic              dst_ok, src0_ok, ch_ready, stall;
  logic              wr_en, take_branch, push, pop, set_ovf, set_unf, led_we, put_active;
  logic [DATA_W-1:0] wr_data, put_value;

  assign op          = opcode_e'(ir[INSN_W-1 -: 4]);
  assign dst         = ir[3*ADDR_W-1 -: ADDR_W];
  assign src1        = ir[2*ADDR_W-1 -: ADDR_W];
  assign src0        = ir[ADDR_W-1:0];
  assign opa         = regs[src1];
  assign opb         = regs[src0];
  assign imm         = DATA_W'({src1, src0});
  assign jump_target = IP_W'(dst);
  assign top_idx     = (SP_W - 1)'(sp - 1'b1);
  assign dst_ch      = dst[CH_W-1:0];
  assign src0_ch     = src0[CH_W-1:0];
  assign dst_ok      = {1'b0, dst} < CH_LIMIT;
  assign src0_ok     = {1'b0, src0} < CH_LIMIT;

  // Execute-stage decode: every side effect of the instruction in IR.
  always_comb begin
    wr_en       = 1'b0;
    wr_data     = '0;
    take_branch = 1'b0;
    target      = jump_target;
    push        = 1'b0;
    pop         = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    led_we      = 1'b0;
    put_active  = 1'b0;
    put_value   = '0;
    case (op)
      OP_ADD:  begin wr_en = 1'b1; wr_data = opa + opb; end
      OP_SUB:  begin wr_en = 1'b1; wr_data = opa - opb; end
      OP_STO:  begin wr_en = 1'b1; wr_data = imm; end
      OP_MUL:  begin wr_en = 1'b1; wr_data = opa * opb; end
      OP_BLE:  take_branch = (opa <= opb);
      OP_JMP:  take_branch = 1'b1;
      OP_CALL: begin
        if (sp == SP_FULL) set_ovf = 1'b1;
        else begin push = 1'b1; take_branch = 1'b1; end
      end
      OP_RET: begin
        if (sp == '0) set_unf = 1'b1;
        else begin pop = 1'b1; take_branch = 1'b1; target = stack[top_idx]; end
      end
      OP_LED:   led_we = 1'b1;
      OP_BNRDY: take_branch = src0_ok && !iOut_Ready[src0_ch];
      OP_PUTI:  if (dst_ok) begin put_active = 1'b1; put_value = imm; end
      OP_PUTR:  if (dst_ok) begin put_active = 1'b1; put_value = opb; end
      default: ;
    endcase
  end

  assign ch_ready = iOut_Ready[dst_ch];
  assign stall    = put_active && !ch_ready;

  // WAIT serves the output data from the captured copy so it cannot drift while stalled.
  always_comb begin
    ch_next = ch_state;
    case (ch_state)
      CH_IDLE: if (stall) ch_next = CH_WAIT;
      CH_WAIT: if (!stall) ch_next = CH_IDLE;
      default: ch_next = CH_IDLE;
    endcase
  end

  assign oIP        = ip;
  assign oStall     = stall;
  assign oOut_Valid = put_active ? (PERIPH_CH'(1) << dst_ch) : '0;
  assign oOut_Data  = (put_active && ch_state == CH_IDLE) ? put_value : data_hold;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ip        <= '0;
      ir        <= '0;
      sp        <= '0;
      oLed      <= '0;
      oStackOvf <= 1'b0;
      oStackUnf <= 1'b0;
      data_hold <= '0;
      ch_state  <= CH_IDLE;
    end else begin
      ch_state <= ch_next;
      if (put_active) data_hold <= put_value;
      if (!stall) begin
        ir <= take_branch ? '0 : iInstruction;
        ip <= take_branch ? target : ip + 1'b1;
        if (push) sp <= sp + 1'b1;
        else if (pop) sp <= sp - 1'b1;
        if (led_we) oLed <= opa[7:0];
        if (set_ovf) oStackOvf <= 1'b1;
        if (set_unf) oStackUnf <= 1'b1;
      end
    end
  end

  // Register file and return stack are storage only and are never cleared.
  always_ff @(posedge Clock) begin
    if (Reset && !stall) begin
      if (wr_en) regs[dst] <= wr_data;
      if (push) stack[sp[SP_W-2:0]] <= ip;
    end
  end
endmodule

// File: tb/tb_mini_alu_core_gen2.sv
// Bench for mini_alu_core_gen2: directed handshake/reset timing steps and
// random programs compared against an instruction-level interpreter.
module tb_mini_alu_core_gen2;
  localparam int DATA_W = 16, ADDR_W = 8, IP_W = 16, STACK_DEPTH = 8, PERIPH_CH = 2;
  localparam int INSN_W = 4 + 3 * ADDR_W;

  logic                 Clock = 1'b0;
  logic                 Reset = 1'b0;
  logic [IP_W-1:0]      oIP;
  logic [INSN_W-1:0]    iInstruction;
  logic [7:0]           oLed;
  logic [DATA_W-1:0]    oOut_Data;
  logic [PERIPH_CH-1:0] oOut_Valid;
  logic [PERIPH_CH-1:0] iOut_Ready = '0;
  logic                 oStall, oStackOvf, oStackUnf;

  logic [INSN_W-1:0] rom [256];
  logic [16:0]       act_q[$];
  logic [16:0]       exp_q[$];
  logic [15:0]       m_regs [256];
  int                m_stack[$];
  logic [7:0]        m_led;
  logic              m_ovf, m_unf;
  int                n_checks = 0;
  int                n_fail = 0;

  always #5 Clock = ~Clock;
  assign iInstruction = rom[oIP[7:0]];

  mini_alu_core_gen2 #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IP_W(IP_W),
    .STACK_DEPTH(STACK_DEPTH), .PERIPH_CH(PERIPH_CH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oLed(oLed), .oOut_Data(oOut_Data), .oOut_Valid(oOut_Valid),
    .iOut_Ready(iOut_Ready), .oStall(oStall), .oStackOvf(oStackOvf),
    .oStackUnf(oStackUnf)
  );

  // Records every transfer that the coming rising edge will complete.
  always @(negedge Clock) begin
    #1;
    if (Reset && (oOut_Valid & iOut_Ready) != '0)
      act_q.push_back({oOut_Valid[1], oOut_Data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [INSN_W-1:0] mk(input int op, input int d, input int s1, input int s0);
    return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
  endfunction

  function automatic logic [INSN_W-1:0] sto(input int d, input int value);
    return mk(3, d, value >> 8, value & 255);
  endfunction

  task automatic clearRom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  // Architectural interpreter: runs the program in order until the halt address.
  task automatic runModel(input int halt);
    int pc, steps, op, d, s1, s0, nxt;
    logic [15:0] a, b, imm;
    exp_q.delete();
    m_stack.delete();
    m_led = '0; m_ovf = 1'b0; m_unf = 1'b0;
    pc = 0; steps = 0;
    while (pc != halt && steps < 2000) begin
      op = int'(rom[pc][27:24]); d = int'(rom[pc][23:16]);
      s1 = int'(rom[pc][15:8]);  s0 = int'(rom[pc][7:0]);
      a = m_regs[s1]; b = m_regs[s0]; imm = {s1[7:0], s0[7:0]};
      nxt = pc + 1;
      steps++;
      case (op)
        1: m_regs[d] = a + b;
        2: m_regs[d] = a - b;
        3: m_regs[d] = imm;
        4: if (a <= b) nxt = d;
        5: nxt = d;
        6: if (m_stack.size() == STACK_DEPTH) m_ovf = 1'b1;
           else begin m_stack.push_back(pc + 1); nxt = d; end
        7: if (m_stack.size() == 0) m_unf = 1'b1;
           else nxt = m_stack.pop_back();
        8: m_led = a[7:0];
        9: m_regs[d] = 16'((int'(a) * int'(b)) & 32'hFFFF);
        11: if (d < PERIPH_CH) exp_q.push_back({d[0], imm});
        12: if (d < PERIPH_CH) exp_q.push_back({d[0], b});
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  task automatic applyReset();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    act_q.delete();
    Reset = 1'b1;
  endtask

  // Runs the loaded program until the halt word executes, then compares with the model.
  task automatic applyStimulus(input string name, input int halt, input bit rnd);
    int cycles;
    cycles = 0;
    runModel(halt);
    iOut_Ready = rnd ? 2'($urandom_range(0, 3)) : 2'b11;
    applyReset();
    do begin
      @(negedge Clock);
      if (rnd) iOut_Ready = 2'($urandom_range(0, 3));
      cycles++;
      #2;
    end while (oIP != IP_W'(halt + 1) && cycles < 3000);
    checkOutput({name, " halt reached"}, 32'(cycles < 3000), 32'd1);
    checkOutput({name, " transfer count"}, 32'(act_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < act_q.size()) checkOutput({name, " transfer"}, 32'(act_q[i]), 32'(exp_q[i]));
    checkOutput({name, " led"}, 32'(oLed), 32'(m_led));
    checkOutput({name, " ovf"}, 32'(oStackOvf), 32'(m_ovf));
    checkOutput({name, " unf"}, 32'(oStackUnf), 32'(m_unf));
  endtask

  function automatic logic [INSN_W-1:0] randInsn(input int addr);
    int d, s1, s0;
    d = $urandom_range(0, 7); s1 = $urandom_range(0, 7); s0 = $urandom_range(0, 7);
    case ($urandom_range(0, 10))
      0: return mk(1, d, s1, s0);
      1: return mk(2, d, s1, s0);
      2: return mk(9, d, s1, s0);
      3: return sto(d, $urandom_range(0, 65535));
      4: return mk(8, 0, s1, 0);
      5: return mk(11, $urandom_range(0, 2), $urandom_range(0, 255), $urandom_range(0, 255));
      6: return mk(12, $urandom_range(0, 2), 0, s0);
      7: return mk(4, addr + $urandom_range(1, 3), s1, s0);
      8: return mk(5, addr + $urandom_range(1, 3), 0, 0);
      9: return mk($urandom_range(13, 15), d, s1, s0);
      default: return mk(0, 0, 0, 0);
    endcase
  endfunction

  initial begin
    clearRom();
    repeat (2) @(negedge Clock);
    #2;
    checkOutput("reset ip", 32'(oIP), 32'd0);
    checkOutput("reset valid", 32'(oOut_Valid), 32'd0);
    checkOutput("reset data", 32'(oOut_Data), 32'd0);
    checkOutput("reset stall", 32'(oStall), 32'd0);
    checkOutput("reset led", 32'(oLed), 32'd0);
    checkOutput("reset flags", 32'({oStackOvf, oStackUnf}), 32'd0);

    // PUTI with ready held low for four cycles, then ready rises.
    clearRom();
    rom[0] = mk(11, 0, 8'h00, 8'h41);
    rom[1] = mk(5, 1, 0, 0);
    iOut_Ready = 2'b00;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock); #2;
      checkOutput("wait stall", 32'(oStall), 32'd1);
      checkOutput("wait valid", 32'(oOut_Valid), 32'd1);
      checkOutput("wait data", 32'(oOut_Data), 32'h41);
      checkOutput("wait ip frozen", 32'(oIP), 32'd1);
    end
    @(negedge Clock);
    iOut_Ready = 2'b01;
    #2;
    checkOutput("ready stall", 32'(oStall), 32'd0);
    checkOutput("ready valid", 32'(oOut_Valid), 32'd1);
    @(negedge Clock); #2;
    checkOutput("retire valid", 32'(oOut_Valid), 32'd0);
    checkOutput("retire ip", 32'(oIP), 32'd2);
    checkOutput("single transfer", 32'(act_q.size() == 1 ? act_q[0] : 17'h1FFFF), 32'h00041);

    // Ready already high: no stall cycle at all.
    iOut_Ready = 2'b01;
    applyReset();
    @(negedge Clock); #2;
    checkOutput("fast stall", 32'(oStall), 32'd0);
    checkOutput("fast valid", 32'(oOut_Valid), 32'd1);
    @(negedge Clock); #2;
    checkOutput("fast retire valid", 32'(oOut_Valid), 32'd0);
    checkOutput("fast count", 32'(act_q.size()), 32'd1);

    // Underflow flag set, then reset while waiting on the channel.
    clearRom();
    rom[0] = mk(7, 0, 0, 0);
    rom[1] = mk(11, 0, 8'h00, 8'h41);
    rom[2] = mk(5, 2, 0, 0);
    iOut_Ready = 2'b00;
    applyReset();
    repeat (2) @(negedge Clock);
    #2;
    checkOutput("pre-reset stall", 32'(oStall), 32'd1);
    checkOutput("pre-reset unf", 32'(oStackUnf), 32'd1);
    Reset = 1'b0;
    @(negedge Clock); #2;
    checkOutput("reset-wait valid", 32'(oOut_Valid), 32'd0);
    checkOutput("reset-wait ip", 32'(oIP), 32'd0);
    checkOutput("reset-wait unf", 32'(oStackUnf), 32'd0);
    checkOutput("reset-wait stall", 32'(oStall), 32'd0);
    checkOutput("reset-wait data", 32'(oOut_Data), 32'd0);

    // BNRDY on channel 1 spins until its ready rises.
    clearRom();
    rom[0] = mk(10, 0, 0, 1);
    rom[1] = mk(11, 0, 8'h00, 8'h77);
    rom[2] = mk(5, 2, 0, 0);
    iOut_Ready = 2'b01;
    applyReset();
    repeat (10) @(negedge Clock);
    #2;
    checkOutput("bnrdy spin count", 32'(act_q.size()), 32'd0);
    checkOutput("bnrdy spin ip", 32'(oIP <= 1), 32'd1);
    @(negedge Clock);
    iOut_Ready = 2'b11;
    for (int i = 0; i < 20 && oIP != 3; i++) @(negedge Clock);
    #2;
    checkOutput("bnrdy exit ip", 32'(oIP), 32'd3);
    checkOutput("bnrdy transfer", 32'(act_q.size() == 1 ? act_q[0] : 17'h1FFFF), 32'h00077);

    // Arithmetic, LED, wrap-around subtraction and multiply.
    clearRom();
    rom[0] = sto(1, 5);  rom[1] = sto(2, 3);  rom[2] = mk(2, 3, 1, 2);
    rom[3] = mk(8, 0, 3, 0); rom[4] = sto(4, 0); rom[5] = sto(5, 1);
    rom[6] = mk(2, 6, 4, 5); rom[7] = mk(12, 1, 0, 6); rom[8] = mk(9, 7, 1, 2);
    rom[9] = mk(12, 0, 0, 7); rom[10] = mk(5, 10, 0, 0);
    applyStimulus("arith", 10, 1'b0);
    checkOutput("arith led", 32'(oLed), 32'h02);
    checkOutput("arith wrap", 32'(act_q.size() > 0 ? act_q[0] : 17'h0), 32'h1FFFF);

    // BLE taken on equality; the two skipped STOs never write R7.
    clearRom();
    rom[0] = sto(1, 3); rom[1] = sto(2, 3); rom[2] = sto(7, 8'h11);
    rom[3] = mk(4, 6, 1, 2); rom[4] = sto(7, 12'hBAD); rom[5] = sto(7, 12'hBAD);
    rom[6] = mk(12, 0, 0, 7); rom[7] = mk(5, 7, 0, 0);
    applyStimulus("ble", 7, 1'b0);
    checkOutput("ble squash", 32'(act_q.size() > 0 ? act_q[0] : 17'h0), 32'h00011);

    // Nested CALL depth 3 then three RETs.
    clearRom();
    rom[0] = mk(6, 4, 0, 0);  rom[1] = mk(11, 0, 0, 8'hA1); rom[2] = mk(5, 2, 0, 0);
    rom[4] = mk(6, 7, 0, 0);  rom[5] = mk(11, 0, 0, 8'hA2); rom[6] = mk(7, 0, 0, 0);
    rom[7] = mk(6, 10, 0, 0); rom[8] = mk(11, 0, 0, 8'hA3); rom[9] = mk(7, 0, 0, 0);
    rom[10] = mk(11, 0, 0, 8'hA4); rom[11] = mk(7, 0, 0, 0);
    applyStimulus("nested", 2, 1'b1);
    checkOutput("nested first", 32'(act_q.size() == 4 ? act_q[0] : 17'h0), 32'h000A4);
    checkOutput("nested last", 32'(act_q.size() == 4 ? act_q[3] : 17'h0), 32'h000A1);

    // Nine nested CALLs: the ninth overflows and falls through.
    clearRom();
    for (int k = 0; k < 9; k++) rom[k] = mk(6, k + 1, 0, 0);
    rom[9] = mk(11, 0, 0, 8'h55); rom[10] = mk(5, 10, 0, 0);
    applyStimulus("overflow", 10, 1'b0);
    checkOutput("overflow flag", 32'(oStackOvf), 32'd1);

    // Reserved opcodes and a PUT to a missing channel change nothing.
    clearRom();
    rom[0] = sto(1, 16'h1234); rom[1] = mk(14, 1, 1, 1); rom[2] = mk(13, 2, 3, 4);
    rom[3] = mk(15, 1, 0, 0); rom[4] = mk(11, 2, 0, 5); rom[5] = mk(12, 0, 0, 1);
    rom[6] = mk(5, 6, 0, 0);
    applyStimulus("reserved", 6, 1'b0);
    checkOutput("reserved r1", 32'(act_q.size() == 1 ? act_q[0] : 17'h0), 32'h01234);

    // Random programs with random ready back-pressure.
    for (int r = 0; r < 6; r++) begin
      clearRom();
      for (int k = 0; k < 8; k++) rom[k] = sto(k, $urandom_range(0, 65535));
      for (int k = 8; k < 28; k++) rom[k] = randInsn(k);
      for (int k = 0; k < 8; k++) rom[28 + k] = mk(12, k % 2, 0, k);
      rom[36] = mk(5, 36, 0, 0);
      applyStimulus("random", 36, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
